// File: rtl/calc_sequencer.sv
// Calculator input sequencer: debounces keypad events, assembles two decimal operands
// and an operator, drives the ALU handshake and holds the result. Optional macro: CALC_CHAIN_EN.
module calc_sequencer #(
    parameter int W          = 8,
    parameter int DIGITS     = 2,
    parameter int DEB_CYCLES = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               btn_pressed,
    input  logic [3:0]         btn_code,
    output logic [W-1:0]       op_a,
    output logic [W-1:0]       op_b,
    output logic [1:0]         op_sel,
    output logic               alu_start,
    input  logic               alu_done,
    input  logic [2*W-1:0]     alu_result,
    output logic [2*W-1:0]     disp_value,
    output logic               busy,
    output logic               key_stb
);

    localparam int DBW = $clog2(DEB_CYCLES + 1);
    localparam int CW  = $clog2(DIGITS + 1);
    localparam logic [DBW-1:0] DEB_MAX = DBW'(DEB_CYCLES);
    localparam logic [CW-1:0]  CNT_MAX = CW'(DIGITS);

    typedef enum logic [1:0] {S_A, S_B, EXEC, S_RES} state_t;

    logic           pressed_s;
    logic [3:0]     code_s, code_prev, key_code;
    logic [DBW-1:0] press_cnt, press_cnt_nxt, rel_cnt, rel_cnt_nxt;
    logic           armed, stb_cond;

    always_comb begin
        press_cnt_nxt = '0;
        rel_cnt_nxt   = '0;
        if (pressed_s) begin
            if (code_s != code_prev)
                press_cnt_nxt = DBW'(1);
            else if (press_cnt == DEB_MAX)
                press_cnt_nxt = DEB_MAX;
            else
                press_cnt_nxt = press_cnt + 1'b1;
        end else begin
            if (rel_cnt == DEB_MAX)
                rel_cnt_nxt = DEB_MAX;
            else
                rel_cnt_nxt = rel_cnt + 1'b1;
        end
        stb_cond = armed && (press_cnt_nxt == DEB_MAX);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pressed_s <= 1'b0;
            code_s    <= '0;
            code_prev <= '0;
            press_cnt <= '0;
            rel_cnt   <= '0;
            armed     <= 1'b1;
            key_stb   <= 1'b0;
            key_code  <= '0;
        end else begin
            pressed_s <= btn_pressed;
            code_s    <= btn_code;
            code_prev <= code_s;
            press_cnt <= press_cnt_nxt;
            rel_cnt   <= rel_cnt_nxt;
            key_stb   <= stb_cond;
            if (stb_cond) begin
                armed    <= 1'b0;
                key_code <= code_s;
            end else if (rel_cnt_nxt == DEB_MAX) begin
                armed <= 1'b1;
            end
        end
    end

    function automatic logic [W-1:0] shift_in(input logic [W-1:0] acc, input logic [3:0] d);
        return acc * W'(10) + W'(d);
    endfunction

    state_t         state, state_nxt;
    logic [W-1:0]   a, a_nxt, b, b_nxt;
    logic [CW-1:0]  cnt_a, cnt_a_nxt, cnt_b, cnt_b_nxt;
    logic [1:0]     op_sel_nxt, op_code;
    logic [2*W-1:0] result, result_nxt, disp_nxt;
    logic           is_digit, is_op, is_eq, is_clr;

    // Key codes 10..13 map onto op_sel 00..11 by flipping bit 1.
    assign op_code  = key_code[1:0] ^ 2'b10;
    assign is_digit = key_stb && (key_code < 4'd10);
    assign is_op    = key_stb && (key_code >= 4'd10) && (key_code <= 4'd13);
    assign is_eq    = key_stb && (key_code == 4'd14);
    assign is_clr   = key_stb && (key_code == 4'd15);

    always_comb begin
        state_nxt  = state;
        a_nxt      = a;
        b_nxt      = b;
        cnt_a_nxt  = cnt_a;
        cnt_b_nxt  = cnt_b;
        op_sel_nxt = op_sel;
        result_nxt = result;
        if (state != EXEC && is_clr) begin
            state_nxt  = S_A;
            a_nxt      = '0;
            b_nxt      = '0;
            cnt_a_nxt  = '0;
            cnt_b_nxt  = '0;
            op_sel_nxt = '0;
            result_nxt = '0;
        end else begin
            case (state)
                S_A: begin
                    if (is_digit && cnt_a < CNT_MAX) begin
                        a_nxt     = shift_in(a, key_code);
                        cnt_a_nxt = cnt_a + 1'b1;
                    end else if (is_op) begin
                        op_sel_nxt = op_code;
                        b_nxt      = '0;
                        cnt_b_nxt  = '0;
                        state_nxt  = S_B;
                    end
                end
                S_B: begin
                    if (is_digit && cnt_b < CNT_MAX) begin
                        b_nxt     = shift_in(b, key_code);
                        cnt_b_nxt = cnt_b + 1'b1;
                    end else if (is_op && cnt_b == '0) begin
                        op_sel_nxt = op_code;
                    end else if (is_eq && cnt_b != '0) begin
                        state_nxt = EXEC;
                    end
                end
                EXEC: begin
                    if (alu_done) begin
                        result_nxt = alu_result;
                        state_nxt  = S_RES;
                    end
                end
                S_RES: begin
                    if (is_digit) begin
                        a_nxt     = W'(key_code);
                        cnt_a_nxt = CW'(1);
                        state_nxt = S_A;
                    end
`ifdef CALC_CHAIN_EN
                    else if (is_op && result[2*W-1:W] == '0) begin
                        a_nxt      = result[W-1:0];
                        cnt_a_nxt  = CNT_MAX;
                        op_sel_nxt = op_code;
                        b_nxt      = '0;
                        cnt_b_nxt  = '0;
                        state_nxt  = S_B;
                    end
`endif
                end
                default: state_nxt = S_A;
            endcase
        end

        case (state_nxt)
            S_A:     disp_nxt = {{W{1'b0}}, a_nxt};
            S_B:     disp_nxt = (cnt_b_nxt != '0) ? {{W{1'b0}}, b_nxt} : {{W{1'b0}}, a_nxt};
            S_RES:   disp_nxt = result_nxt;
            default: disp_nxt = disp_value;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_A;
            a          <= '0;
            b          <= '0;
            cnt_a      <= '0;
            cnt_b      <= '0;
            op_sel     <= '0;
            result     <= '0;
            disp_value <= '0;
            alu_start  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_nxt;
            a          <= a_nxt;
            b          <= b_nxt;
            cnt_a      <= cnt_a_nxt;
            cnt_b      <= cnt_b_nxt;
            op_sel     <= op_sel_nxt;
            result     <= result_nxt;
            disp_value <= disp_nxt;
            // Start pulse and busy are registered off the EXEC entry transition.
            alu_start  <= (state_nxt == EXEC) && (state != EXEC);
            busy       <= (state_nxt == EXEC);
        end
    end

    assign op_a = a;
    assign op_b = b;

endmodule
